// File: rtl/war_game_ctrl.sv
// war_game_ctrl: game-flow sequencer for war_graph; conditions the shoot button,
// derives a per-frame tick, and tracks phase, score and remaining lives.
module war_game_ctrl #(
  parameter int LIVES           = 3,
  parameter int SCORE_W         = 8,
  parameter int PAUSE_FRAMES    = 120,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p_tick,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic               shoot,
  input  logic               hit,
  input  logic               escape,
  output logic               frame_tick,
  output logic               fire,
  output logic               gra_still,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               game_over
);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam int PW = $clog2(PAUSE_FRAMES + 1);
  typedef enum logic [1:0] {NEWGAME, PLAY, NEWLIFE, OVER} state_e;
  state_e               state_q;
  logic                 s0_q, s1_q, s2_q, ft_q, fire_q, still_q, over_q;
  logic [CW-1:0]        cd_q;
  logic [PW-1:0]        pt_q;
  logic [SCORE_W-1:0]   score_q;
  logic [2:0]           lives_q;
  logic                 shoot_edge, expire;
  assign shoot_edge = s1_q & ~s2_q;
  // pause ends on the tick that takes the timer from 1 to 0
  assign expire     = ft_q && pt_q == PW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      {s0_q, s1_q, s2_q, ft_q, fire_q, over_q} <= '0;
      still_q <= 1'b1;
      state_q <= NEWGAME;
      cd_q    <= '0;
      pt_q    <= '0;
      score_q <= '0;
      lives_q <= 3'(LIVES);
    end else begin
      s0_q   <= shoot;
      s1_q   <= s0_q;
      s2_q   <= s1_q;
      ft_q   <= p_tick && pixel_x == 10'd0 && pixel_y == 10'd480;
      fire_q <= 1'b0;
      if (ft_q && cd_q != '0) cd_q <= cd_q - CW'(1);
      if (ft_q && pt_q != '0) pt_q <= pt_q - PW'(1);
      case (state_q)
        NEWGAME: if (shoot_edge) begin
          score_q <= '0;
          lives_q <= 3'(LIVES);
          cd_q    <= '0;
          still_q <= 1'b0;
          state_q <= PLAY;
        end
        PLAY: begin
          if (shoot_edge && cd_q == '0) begin
            fire_q <= 1'b1;
            cd_q   <= CW'(COOLDOWN_FRAMES);
          end
          if (hit && score_q != '1) score_q <= score_q + 1'b1;
          if (escape) begin
            lives_q <= lives_q - 3'd1;
            pt_q    <= PW'(PAUSE_FRAMES);
            still_q <= 1'b1;
            over_q  <= lives_q == 3'd1;
            state_q <= lives_q == 3'd1 ? OVER : NEWLIFE;
          end
        end
        NEWLIFE: if (expire) begin
          cd_q    <= '0;
          still_q <= 1'b0;
          state_q <= PLAY;
        end
        OVER: if (expire) begin
          over_q  <= 1'b0;
          state_q <= NEWGAME;
        end
      endcase
    end
  end
  assign frame_tick = ft_q;
  assign fire       = fire_q;
  assign gra_still  = still_q;
  assign state      = state_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign game_over  = over_q;
endmodule

// File: tb/tb_war_game_ctrl.sv
// tb_war_game_ctrl: directed game sequence; fire pulses are matched against a
// queue of expected cycle numbers filled when each shot is pressed.
module tb_war_game_ctrl;
  logic       clk = 1'b0, reset = 1'b1, p_tick = 1'b0, shoot = 1'b0, hit = 1'b0, escape = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0;
  logic       frame_tick, fire, gra_still, game_over;
  logic [1:0] state;
  logic [3:0] score;
  logic [2:0] lives;
  int         total = 0, bad = 0, cyc = 0;
  int         exp_fire[$];
  logic       prev_fire = 1'b0;

  war_game_ctrl #(.LIVES(3), .SCORE_W(4), .PAUSE_FRAMES(120), .COOLDOWN_FRAMES(8)) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .shoot(shoot), .hit(hit), .escape(escape), .frame_tick(frame_tick), .fire(fire),
    .gra_still(gra_still), .state(state), .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fire) begin
      total++;
      if (exp_fire.size() == 0) begin
        assert (0) else begin bad++; $error("FAIL fire_unexpected: fire=1 at cycle %0d, none expected", cyc); end
      end else begin
        int e;
        e = exp_fire.pop_front();
        assert (cyc === e) else begin bad++; $error("FAIL fire_time: fire at cycle %0d, expected cycle %0d", cyc, e); end
      end
      total++;
      assert (prev_fire === 1'b0) else begin bad++; $error("FAIL fire_double: fire high two cycles, got 1 want 0"); end
    end
    prev_fire = fire;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin bad++; $error("FAIL %s: got %0d want %0d", tag, obs, exp); end
  endtask

  task automatic press(input int hold, input bit expect_fire);
    shoot = 1'b1;
    if (expect_fire) exp_fire.push_back(cyc + 3);
    step(hold);
    shoot = 1'b0;
    step(4);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
      step(1);
      p_tick = 1'b0; pixel_y = 10'd0;
      step(1);
    end
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; step(1); hit = 1'b0; step(1);
    end
  endtask

  initial begin
    step(2);
    chk("rst_state", state, 0);
    chk("rst_still", gra_still, 1);
    chk("rst_fire", fire, 0);
    chk("rst_ftick", frame_tick, 0);
    chk("rst_over", game_over, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    reset = 1'b0;
    step(1);
    // start: state changes three edges after shoot is first sampled
    shoot = 1'b1;
    step(2);
    chk("start_wait", state, 0);
    step(1);
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    chk("start_still", gra_still, 0);
    step(97);
    shoot = 1'b0;
    step(4);
    // frame tick decode
    p_tick = 1'b0; pixel_x = 10'd0; pixel_y = 10'd480;
    step(2);
    chk("ftick_no_ptick", frame_tick, 0);
    p_tick = 1'b1; pixel_y = 10'd479;
    step(2);
    chk("ftick_wrong_row", frame_tick, 0);
    pixel_y = 10'd480;
    step(1);
    p_tick = 1'b0; pixel_y = 10'd0;
    chk("ftick_pulse", frame_tick, 1);
    step(1);
    chk("ftick_single", frame_tick, 0);
    // shot and cooldown
    press(4, 1'b1);
    ticks(3);
    press(4, 1'b0);
    ticks(6);
    press(4, 1'b1);
    // score and first life lost
    pulse_hit(2);
    chk("hit_score", score, 2);
    escape = 1'b1; step(1); escape = 1'b0;
    chk("esc1_lives", lives, 2);
    chk("esc1_state", state, 2);
    chk("esc1_still", gra_still, 1);
    chk("esc1_over", game_over, 0);
    step(1);
    press(4, 1'b0);
    pulse_hit(1);
    chk("newlife_hit_ignored", score, 2);
    ticks(119);
    chk("newlife_119", state, 2);
    ticks(1);
    chk("newlife_120", state, 1);
    chk("resume_still", gra_still, 0);
    press(4, 1'b1);
    // second life lost, then game over with simultaneous hit
    escape = 1'b1; step(1); escape = 1'b0;
    chk("esc2_lives", lives, 1);
    ticks(120);
    chk("resume2_state", state, 1);
    hit = 1'b1; escape = 1'b1; step(1); hit = 1'b0; escape = 1'b0;
    chk("over_score", score, 3);
    chk("over_lives", lives, 0);
    chk("over_state", state, 3);
    chk("over_flag", game_over, 1);
    chk("over_still", gra_still, 1);
    step(1);
    press(4, 1'b0);
    ticks(119);
    chk("over_119", state, 3);
    ticks(1);
    chk("newgame_state", state, 0);
    chk("newgame_score_kept", score, 3);
    chk("newgame_over", game_over, 0);
    chk("newgame_still", gra_still, 1);
    // new game clears score; then saturation at 2^4-1
    press(4, 1'b0);
    chk("game2_state", state, 1);
    chk("game2_score", score, 0);
    chk("game2_lives", lives, 3);
    pulse_hit(15);
    chk("sat_15", score, 15);
    pulse_hit(5);
    chk("sat_20", score, 15);
    // reset mid-pause, with a frame-tick condition present in the reset cycle
    escape = 1'b1; step(1); escape = 1'b0;
    chk("esc3_state", state, 2);
    ticks(70);
    reset = 1'b1; p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd480;
    step(1);
    reset = 1'b0; p_tick = 1'b0; pixel_y = 10'd0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_still", gra_still, 1);
    chk("mid_rst_fire", fire, 0);
    chk("mid_rst_ftick", frame_tick, 0);
    chk("mid_rst_over", game_over, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_lives", lives, 3);
    step(1);
    chk("post_rst_ftick", frame_tick, 0);
    step(2);
    chk("fire_queue_empty", exp_fire.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
